sram_like_arbiter: RTL and testbench

SRAM_LIKE_ARBITER -- requirements
Module: sram_like_arbiter

---
 rtl/sram_like_arbiter_if.sv | 28 ++
 rtl/sram_like_arbiter.sv | 146 ++++++++++++++
 tb/tb_sram_like_arbiter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/sram_like_arbiter_if.sv
// sram_like_arbiter_if
// One SRAM-like request/response channel.
//   req/wr/size/wstrb/addr/wdata : request bundle, driven by the master
//   addr_ok                      : request accepted, driven by the slave
//   data_ok/rdata                : response valid / read data, driven by the slave
// The arbiter is a slave on the instruction and data channels and a master on
// the shared memory channel.
interface sram_like_arbiter_if;
   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic [3:0]  wstrb;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;

   modport master (
      output req, wr, size, wstrb, addr, wdata,
      input  addr_ok, data_ok, rdata
   );

   modport slave (
      input  req, wr, size, wstrb, addr, wdata,
      output addr_ok, data_ok, rdata
   );
endinterface

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter
// Merges the CPU instruction (ID 0) and data (ID 1) SRAM-like channels onto one
// memory channel. Grant is combinational with data priority, held by a lock
// while the memory stalls a request. Accepted IDs go into an in-order FIFO so
// responses are steered back to the requester that issued them.
//   clk         : clock
//   resetn      : asynchronous active-low reset
//   i_bus       : instruction channel (slave side)
//   d_bus       : data channel (slave side)
//   m_bus       : memory channel (master side)
//   outstanding : accepted-but-unanswered transaction count
//
// state        | meaning
// ST_UNLOCKED  | grant chosen freshly each cycle, data port wins ties
// ST_LOCKED    | a request is stalled on m_bus; r_lock_id stays granted
module sram_like_arbiter #(
   parameter int OUTSTANDING = 2
) (
   input  logic                  clk,
   input  logic                  resetn,
   sram_like_arbiter_if.slave    i_bus,
   sram_like_arbiter_if.slave    d_bus,
   sram_like_arbiter_if.master   m_bus,
   output logic [2:0]            outstanding
);

   localparam int          PTR_W    = $clog2(OUTSTANDING);
   localparam logic [2:0]  FULL_CNT = 3'(OUTSTANDING);

   if (OUTSTANDING != 2 && OUTSTANDING != 4) begin : g_bad_outstanding
      $error("sram_like_arbiter: OUTSTANDING must be 2 or 4");
   end

   typedef enum logic {
      ST_UNLOCKED = 1'b0,
      ST_LOCKED   = 1'b1
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic                    r_lock_id;
   logic                    w_lock_id_nxt;

   logic [OUTSTANDING-1:0]  r_fifo;
   logic [PTR_W-1:0]        r_wptr;
   logic [PTR_W-1:0]        r_rptr;
   logic [2:0]              r_count;

   logic                    w_grant;
   logic                    w_full;
   logic                    w_empty;
   logic                    w_m_req;
   logic                    w_push;
   logic                    w_pop;
   logic                    w_head_id;

   assign w_full    = (r_count == FULL_CNT);
   assign w_empty   = (r_count == 3'd0);
   assign w_head_id = r_fifo[r_rptr];
   assign w_push    = w_m_req & m_bus.addr_ok;
   // A response with nothing outstanding is a slave protocol error; drop it.
   assign w_pop     = m_bus.data_ok & ~w_empty;

   assign outstanding = r_count;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state   <= ST_UNLOCKED;
         r_lock_id <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_lock_id <= w_lock_id_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_lock_id_nxt = r_lock_id;
      w_grant       = 1'b0;
      w_m_req       = 1'b0;

      if (r_state == ST_LOCKED) begin
         w_grant = r_lock_id;
      end else begin
         w_grant = d_bus.req;
      end

      w_m_req = (w_grant ? d_bus.req : i_bus.req) & ~w_full;

      case (r_state)
         ST_UNLOCKED: begin
            if (w_m_req && !m_bus.addr_ok) begin
               w_state_nxt   = ST_LOCKED;
               w_lock_id_nxt = w_grant;
            end
         end
         ST_LOCKED: begin
            if (w_m_req && m_bus.addr_ok) begin
               w_state_nxt = ST_UNLOCKED;
            end
         end
         default: begin
            w_state_nxt = ST_UNLOCKED;
         end
      endcase

      m_bus.req     = w_m_req;
      m_bus.wr      = w_grant ? d_bus.wr    : i_bus.wr;
      m_bus.size    = w_grant ? d_bus.size  : i_bus.size;
      m_bus.wstrb   = w_grant ? d_bus.wstrb : i_bus.wstrb;
      m_bus.addr    = w_grant ? d_bus.addr  : i_bus.addr;
      m_bus.wdata   = w_grant ? d_bus.wdata : i_bus.wdata;

      i_bus.addr_ok = m_bus.addr_ok & ~w_grant & w_m_req;
      d_bus.addr_ok = m_bus.addr_ok &  w_grant & w_m_req;

      i_bus.data_ok = w_pop & ~w_head_id;
      d_bus.data_ok = w_pop &  w_head_id;
      i_bus.rdata   = m_bus.rdata;
      d_bus.rdata   = m_bus.rdata;
   end

   // ID FIFO; depth is a power of two so pointers wrap naturally.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_fifo  <= '0;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= 3'd0;
      end else begin
         if (w_push) begin
            r_fifo[r_wptr] <= w_grant;
            r_wptr         <= r_wptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 3'd1;
            2'b01:   r_count <= r_count - 3'd1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_like_arbiter.sv
module tb_sram_like_arbiter;

   logic        clk;
   logic        resetn;
   logic [2:0]  outstanding;

   int n_checks;
   int n_errors;

   sram_like_arbiter_if ib();
   sram_like_arbiter_if db();
   sram_like_arbiter_if mb();

   sram_like_arbiter #(.OUTSTANDING(2)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .i_bus       (ib),
      .d_bus       (db),
      .m_bus       (mb),
      .outstanding (outstanding)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs change here.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic idle_inputs();
      ib.req = 1'b0; ib.wr = 1'b0; ib.size = 2'd2; ib.wstrb = 4'h0;
      ib.addr = 32'h0; ib.wdata = 32'h0;
      db.req = 1'b0; db.wr = 1'b0; db.size = 2'd2; db.wstrb = 4'h0;
      db.addr = 32'h0; db.wdata = 32'h0;
      mb.addr_ok = 1'b0; mb.data_ok = 1'b0; mb.rdata = 32'h0;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      idle_inputs();
      resetn = 1'b0;

      // Under reset: outputs still combinational, nothing recorded.
      #2;
      chk("rst_outstanding", 32'(outstanding), 32'd0);
      chk("rst_mreq_idle", 32'(mb.req), 32'd0);
      ib.req = 1'b1; ib.addr = 32'h0000_1000; mb.addr_ok = 1'b1;
      settle();
      chk("rst_mreq_follow", 32'(mb.req), 32'd1);
      chk("rst_i_addr_ok", 32'(ib.addr_ok), 32'd1);
      tick();
      chk("rst_no_push", 32'(outstanding), 32'd0);
      idle_inputs();
      resetn = 1'b1;
      tick();

      // Contention: data wins.
      ib.req = 1'b1; ib.addr = 32'h0000_1000;
      db.req = 1'b1; db.addr = 32'h0000_2000;
      mb.addr_ok = 1'b1;
      settle();
      chk("cont_d_addr_ok", 32'(db.addr_ok), 32'd1);
      chk("cont_i_addr_ok", 32'(ib.addr_ok), 32'd0);
      chk("cont_m_addr", mb.addr, 32'h0000_2000);
      tick();
      chk("cont_outstanding", 32'(outstanding), 32'd1);
      idle_inputs();
      mb.data_ok = 1'b1; mb.rdata = 32'h0000_0055;
      settle();
      chk("cont_d_data_ok", 32'(db.data_ok), 32'd1);
      chk("cont_i_data_ok", 32'(ib.data_ok), 32'd0);
      chk("cont_d_rdata", db.rdata, 32'h0000_0055);
      tick();
      chk("cont_drained", 32'(outstanding), 32'd0);
      idle_inputs();

      // Lock hold: inst stalled, data arrives, inst stays granted.
      ib.req = 1'b1; ib.addr = 32'h0000_1000;
      db.addr = 32'h0000_2000;
      settle();
      chk("lock_c0_m_addr", mb.addr, 32'h0000_1000);
      tick();
      db.req = 1'b1;
      settle();
      chk("lock_c1_m_addr", mb.addr, 32'h0000_1000);
      chk("lock_c1_d_addr_ok", 32'(db.addr_ok), 32'd0);
      tick();
      settle();
      chk("lock_c2_m_addr", mb.addr, 32'h0000_1000);
      tick();
      mb.addr_ok = 1'b1;
      settle();
      chk("lock_c3_i_addr_ok", 32'(ib.addr_ok), 32'd1);
      chk("lock_c3_d_addr_ok", 32'(db.addr_ok), 32'd0);
      tick();
      chk("lock_outstanding1", 32'(outstanding), 32'd1);
      ib.req = 1'b0;
      settle();
      chk("lock_then_d_addr", mb.addr, 32'h0000_2000);
      chk("lock_then_d_addr_ok", 32'(db.addr_ok), 32'd1);
      tick();
      chk("full_outstanding2", 32'(outstanding), 32'd2);

      // Full: FIFO holds [inst, data]; data request blocked.
      db.addr = 32'h0000_2004;
      settle();
      chk("full_m_req", 32'(mb.req), 32'd0);
      chk("full_d_addr_ok", 32'(db.addr_ok), 32'd0);
      tick();
      chk("full_hold", 32'(outstanding), 32'd2);

      // Full with pop: still blocked this cycle, response to inst.
      mb.data_ok = 1'b1; mb.rdata = 32'h0000_AAAA;
      settle();
      chk("fullpop_i_data_ok", 32'(ib.data_ok), 32'd1);
      chk("fullpop_d_data_ok", 32'(db.data_ok), 32'd0);
      chk("fullpop_i_rdata", ib.rdata, 32'h0000_AAAA);
      chk("fullpop_m_req", 32'(mb.req), 32'd0);
      tick();
      chk("fullpop_outstanding", 32'(outstanding), 32'd1);
      mb.data_ok = 1'b0;
      settle();
      chk("afterpop_m_req", 32'(mb.req), 32'd1);

      // Simultaneous push (inst) and pop (older data) at occupancy 1.
      db.req = 1'b0;
      ib.req = 1'b1; ib.addr = 32'h0000_1008;
      mb.data_ok = 1'b1; mb.rdata = 32'h0000_BBBB;
      settle();
      chk("pp_i_addr_ok", 32'(ib.addr_ok), 32'd1);
      chk("pp_d_data_ok", 32'(db.data_ok), 32'd1);
      chk("pp_i_data_ok", 32'(ib.data_ok), 32'd0);
      chk("pp_d_rdata", db.rdata, 32'h0000_BBBB);
      tick();
      chk("pp_outstanding", 32'(outstanding), 32'd1);
      idle_inputs();
      mb.data_ok = 1'b1; mb.rdata = 32'h0000_CCCC;
      settle();
      chk("pp_queued_i_data_ok", 32'(ib.data_ok), 32'd1);
      chk("pp_queued_d_data_ok", 32'(db.data_ok), 32'd0);
      tick();
      chk("pp_drained", 32'(outstanding), 32'd0);
      idle_inputs();

      // Ordering, with a write on the data side.
      ib.req = 1'b1; ib.addr = 32'h0000_1000;
      mb.addr_ok = 1'b1;
      tick();
      ib.req = 1'b0;
      db.req = 1'b1; db.wr = 1'b1; db.addr = 32'h0000_2000;
      db.wstrb = 4'hC; db.wdata = 32'hDEAD_BEEF; db.size = 2'd1;
      settle();
      chk("ord_m_wr", 32'(mb.wr), 32'd1);
      chk("ord_m_wstrb", 32'(mb.wstrb), 32'hC);
      chk("ord_m_wdata", mb.wdata, 32'hDEAD_BEEF);
      chk("ord_m_size", 32'(mb.size), 32'd1);
      tick();
      chk("ord_outstanding2", 32'(outstanding), 32'd2);
      idle_inputs();
      mb.data_ok = 1'b1; mb.rdata = 32'h0000_AAAA;
      settle();
      chk("ord_first_i_data_ok", 32'(ib.data_ok), 32'd1);
      chk("ord_first_d_data_ok", 32'(db.data_ok), 32'd0);
      chk("ord_first_i_rdata", ib.rdata, 32'h0000_AAAA);
      tick();
      mb.rdata = 32'h0000_BBBB;
      settle();
      chk("ord_second_d_data_ok", 32'(db.data_ok), 32'd1);
      chk("ord_second_i_data_ok", 32'(ib.data_ok), 32'd0);
      chk("ord_second_d_rdata", db.rdata, 32'h0000_BBBB);
      tick();
      chk("ord_drained", 32'(outstanding), 32'd0);

      // Response with empty FIFO is ignored, rdata still passes through.
      mb.rdata = 32'h1234_5678;
      settle();
      chk("empty_i_data_ok", 32'(ib.data_ok), 32'd0);
      chk("empty_d_data_ok", 32'(db.data_ok), 32'd0);
      chk("empty_i_rdata", ib.rdata, 32'h1234_5678);
      tick();
      chk("empty_outstanding", 32'(outstanding), 32'd0);
      idle_inputs();

      // Reset mid-flight discards pending IDs.
      ib.req = 1'b1; ib.addr = 32'h0000_1000;
      mb.addr_ok = 1'b1;
      tick();
      ib.req = 1'b0; db.req = 1'b1; db.addr = 32'h0000_2000;
      tick();
      idle_inputs();
      chk("rstmid_before", 32'(outstanding), 32'd2);
      resetn = 1'b0;
      #1;
      chk("rstmid_cleared", 32'(outstanding), 32'd0);
      #1;
      resetn = 1'b1;
      tick();
      mb.data_ok = 1'b1; mb.rdata = 32'h0000_9999;
      settle();
      chk("rstmid_i_data_ok", 32'(ib.data_ok), 32'd0);
      chk("rstmid_d_data_ok", 32'(db.data_ok), 32'd0);
      tick();
      chk("rstmid_outstanding", 32'(outstanding), 32'd0);
      idle_inputs();
      tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
